// File: rtl/dm_stall_ctrl_pkg.sv
// Shared pipeline constants for the five-stage core: register-field width
// and the data-memory stall controller state encoding.
package dm_stall_ctrl_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ABORT = 2'd2
  } dm_state_e;

endpackage : dm_stall_ctrl_pkg

// File: rtl/dm_stall_ctrl_hazard_detect.sv
// Load-use comparator: flags when the load in EX writes a register that the
// instruction in ID actually reads. Register 0 is hard-wired and never hazards.
module hazard_detect
  import dm_stall_ctrl_pkg::*;
(
  input  logic             dm_re_ID_EX,
  input  logic [REG_W-1:0] dst_ID_EX,
  input  logic [REG_W-1:0] src0_IF_ID,
  input  logic [REG_W-1:0] src1_IF_ID,
  input  logic             src0_vld_IF_ID,
  input  logic             src1_vld_IF_ID,
  output logic             hit
);

  logic dst_nz_s;
  logic src0_match_s;
  logic src1_match_s;

  // Compare both read ports against the pending load destination
  always_comb begin
    dst_nz_s     = (dst_ID_EX != {REG_W{1'b0}});
    src0_match_s = src0_vld_IF_ID & (src0_IF_ID == dst_ID_EX);
    src1_match_s = src1_vld_IF_ID & (src1_IF_ID == dst_ID_EX);
    hit          = dm_re_ID_EX & dst_nz_s & (src0_match_s | src1_match_s);
  end

endmodule : hazard_detect

// File: rtl/dm_stall_ctrl.sv
// Pipeline stall controller: sequences variable-latency data-memory accesses
// from the DM stage and inserts one bubble per load-use hazard.
module dm_stall_ctrl
  import dm_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dm_re_EX_DM,
  input  logic             dm_we_EX_DM,
  input  logic             mem_ack,
  input  logic             dm_re_ID_EX,
  input  logic [REG_W-1:0] dst_ID_EX,
  input  logic [REG_W-1:0] src0_IF_ID,
  input  logic [REG_W-1:0] src1_IF_ID,
  input  logic             src0_vld_IF_ID,
  input  logic             src1_vld_IF_ID,
  output logic             mem_req,
  output logic             mem_we,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_DM,
  output logic             stall_DM_WB,
  output logic             flush_ID_EX,
  output logic             timeout_err
);

  dm_state_e        state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             terr_q, terr_d;

  logic access_s;
  logic req_s;
  logic busy_s;
  logic hit_s;
  logic load_use_s;

  hazard_detect u_hazard_detect (
    .dm_re_ID_EX    (dm_re_ID_EX),
    .dst_ID_EX      (dst_ID_EX),
    .src0_IF_ID     (src0_IF_ID),
    .src1_IF_ID     (src1_IF_ID),
    .src0_vld_IF_ID (src0_vld_IF_ID),
    .src1_vld_IF_ID (src1_vld_IF_ID),
    .hit            (hit_s)
  );

  // Request, busy and load-use qualification; memory stall wins over load-use
  always_comb begin
    access_s   = dm_re_EX_DM | dm_we_EX_DM;
    req_s      = ((state_q == ST_IDLE) & access_s) | (state_q == ST_WAIT);
    busy_s     = req_s & ~mem_ack;
    load_use_s = hit_s & ~busy_s & (state_q != ST_ABORT);
  end

  // Output drive; everything is held low while reset is asserted
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    stall_IF_ID = 1'b0;
    stall_ID_EX = 1'b0;
    stall_EX_DM = 1'b0;
    stall_DM_WB = 1'b0;
    flush_ID_EX = 1'b0;
    timeout_err = 1'b0;
    if (rst) begin
      mem_req = 1'b0;
    end else begin
      mem_req     = req_s;
      mem_we      = req_s & dm_we_EX_DM;
      stall_IF_ID = busy_s | load_use_s;
      stall_ID_EX = busy_s;
      stall_EX_DM = busy_s;
      stall_DM_WB = busy_s;
      flush_ID_EX = load_use_s;
      timeout_err = terr_q;
    end
  end

  // Next-state, wait counter and sticky timeout flag
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    terr_d  = terr_q;
    case (state_q)
      ST_IDLE: begin
        if (access_s & ~mem_ack) begin
          state_d = ST_WAIT;
          wcnt_d  = CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          state_d = ST_IDLE;
        end else if (wcnt_q == CNT_W'(TIMEOUT_CYC)) begin
          state_d = ST_ABORT;
          terr_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= {CNT_W{1'b0}};
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      terr_q  <= terr_d;
    end
  end

endmodule : dm_stall_ctrl

// File: tb/tb_dm_stall_ctrl.sv
// Directed scoreboard bench for dm_stall_ctrl with a short timeout (4 cycles).
module tb_dm_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst, re, we, ack, lre, v0, v1;
  logic [3:0] dst, s0, s1;
  logic       mem_req, mem_we, s_if, s_id, s_ex, s_dm, flush, terr;

  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dm_stall_ctrl #(.TIMEOUT_CYC(4), .CNT_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .dm_re_EX_DM    (re),
    .dm_we_EX_DM    (we),
    .mem_ack        (ack),
    .dm_re_ID_EX    (lre),
    .dst_ID_EX      (dst),
    .src0_IF_ID     (s0),
    .src1_IF_ID     (s1),
    .src0_vld_IF_ID (v0),
    .src1_vld_IF_ID (v1),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .stall_IF_ID    (s_if),
    .stall_ID_EX    (s_id),
    .stall_EX_DM    (s_ex),
    .stall_DM_WB    (s_dm),
    .flush_ID_EX    (flush),
    .timeout_err    (terr)
  );

  // Monitor: one observation per cycle, taken on the falling edge
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {mem_req, mem_we, s_if, s_id, s_ex, s_dm, flush, terr};
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got req/we/sIF/sID/sEX/sDM/flush/terr=%b required %b",
                   e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of memory-side inputs and queue the expected outputs
  task automatic mcyc(input logic r, input logic lr, input logic lw, input logic la,
                      input logic [7:0] e, input string nm);
    exp_t x;
    rst = r; re = lr; we = lw; ack = la;
    x.exp = e; x.name = nm;
    q.push_back(x);
    @(posedge clk); #1;
  endtask

  // Set the hazard-side inputs (ID/EX load and IF/ID sources)
  task automatic haz(input logic l, input logic [3:0] d, input logic [3:0] a,
                     input logic va, input logic [3:0] b, input logic vb);
    lre = l; dst = d; s0 = a; v0 = va; s1 = b; v1 = vb;
  endtask

  initial begin
    haz(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    rst = 1'b1; re = 1'b0; we = 1'b0; ack = 1'b0;
    @(posedge clk); #1;

    // Reset forces all outputs low even with an access present
    mcyc(1'b1, 1'b1, 1'b0, 1'b0, 8'b0000_0000, "reset0");
    mcyc(1'b1, 1'b1, 1'b1, 1'b0, 8'b0000_0000, "reset1");

    // Zero-wait load, then both read and write set -> single write
    mcyc(1'b0, 1'b1, 1'b0, 1'b1, 8'b1000_0000, "zw_load");
    mcyc(1'b0, 1'b1, 1'b1, 1'b1, 8'b1100_0000, "zw_rw");
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, "idle0");

    // Store with ack three cycles after the request
    mcyc(1'b0, 1'b0, 1'b1, 1'b0, 8'b1111_1100, "st3_c0");
    mcyc(1'b0, 1'b0, 1'b1, 1'b0, 8'b1111_1100, "st3_c1");
    mcyc(1'b0, 1'b0, 1'b1, 1'b0, 8'b1111_1100, "st3_c2");
    mcyc(1'b0, 1'b0, 1'b1, 1'b1, 8'b1100_0000, "st3_ack");
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, "idle1");

    // Load-use hits via src1 and src0, and the non-hazard cases
    haz(1'b1, 4'd5, 4'd2, 1'b1, 4'd5, 1'b1);
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 8'b0010_0010, "lu_src1");
    haz(1'b0, 4'd5, 4'd2, 1'b1, 4'd5, 1'b1);
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, "lu_after");
    haz(1'b1, 4'd7, 4'd7, 1'b1, 4'd1, 1'b0);
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 8'b0010_0010, "lu_src0");
    haz(1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 1'b1);
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, "lu_r0");
    haz(1'b1, 4'd5, 4'd2, 1'b1, 4'd5, 1'b0);
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, "lu_novld");

    // Overlap: two-cycle memory wait with a hazard pending
    haz(1'b1, 4'd3, 4'd3, 1'b1, 4'd0, 1'b0);
    mcyc(1'b0, 1'b1, 1'b0, 1'b0, 8'b1011_1100, "ov_c0");
    mcyc(1'b0, 1'b1, 1'b0, 1'b0, 8'b1011_1100, "ov_c1");
    mcyc(1'b0, 1'b1, 1'b0, 1'b1, 8'b1010_0010, "ov_bubble");
    haz(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, "idle2");

    // Timeout: five stall cycles, then ABORT ignores a pending hazard
    for (int i = 0; i < 5; i++) begin
      mcyc(1'b0, 1'b1, 1'b0, 1'b0, 8'b1011_1100, $sformatf("to_c%0d", i));
    end
    haz(1'b1, 4'd3, 4'd3, 1'b1, 4'd0, 1'b0);
    mcyc(1'b0, 1'b1, 1'b0, 1'b0, 8'b0000_0001, "to_abort");
    haz(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0001, "to_sticky");
    mcyc(1'b0, 1'b1, 1'b0, 1'b0, 8'b1011_1101, "post_to_c0");
    mcyc(1'b0, 1'b1, 1'b0, 1'b1, 8'b1000_0001, "post_to_ack");
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0001, "idle3");

    // Reset in the second cycle of a store, then re-issue
    mcyc(1'b0, 1'b0, 1'b1, 1'b0, 8'b1111_1101, "rw_c0");
    mcyc(1'b1, 1'b0, 1'b1, 1'b0, 8'b0000_0000, "rw_rst");
    mcyc(1'b0, 1'b0, 1'b1, 1'b0, 8'b1111_1100, "rw_reissue");
    mcyc(1'b0, 1'b0, 1'b1, 1'b1, 8'b1100_0000, "rw_ack");
    mcyc(1'b0, 1'b0, 1'b0, 1'b0, 8'b0000_0000, "idle4");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_dm_stall_ctrl
